nonce_result_checker: RTL

Consumer end of the nonce path. It starts a search by clearing and enabling the nonce generator, then accepts (nonce, digest) results from the hash core. Each digest is compared against a latched 256-bit target in a 2-stage pipeline. It reports the first winning nonce, or reports exhaustion once the generator overflows and all in-flight work has drained, and holds that result for the host until acknowledged.

---
 rtl/nonce_result_checker.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/nonce_result_checker.sv
// Consumer end of the nonce path: drives the generator, compares hash results
// against a latched target in a two-stage pipeline and holds the search outcome.
module nonce_result_checker #(
    parameter int HASH_W = 256,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic              abort,
    input  logic [HASH_W-1:0] target,
    input  logic              hash_valid,
    input  logic [HASH_W-1:0] hash_digest,
    input  logic [31:0]       hash_nonce,
    input  logic              hash_idle,
    input  logic              gen_overflow,
    output logic              gen_reset,
    output logic              gen_enable,
    output logic              found,
    output logic              exhausted,
    output logic [31:0]       win_nonce,
    output logic [CNT_W-1:0]  checked_count,
    input  logic              result_ack
);

    localparam int HALF = HASH_W / 2;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SEARCH,
        FOUND,
        EXHAUSTED
    } state_t;

    state_t            state_q, state_d;
    logic [HASH_W-1:0] target_q, target_d;
    logic              overflow_seen_q, overflow_seen_d;
    logic              v1_q, v1_d;
    logic [31:0]       nonce1_q, nonce1_d;
    logic              lt_hi_q, lt_hi_d;
    logic              eq_hi_q, eq_hi_d;
    logic [HALF-1:0]   digest_lo_q, digest_lo_d;
    logic              v2_q, v2_d;
    logic [31:0]       nonce2_q, nonce2_d;
    logic              hit_q, hit_d;
    logic [31:0]       win_nonce_q, win_nonce_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic acceptStart;
    logic inSearch;
    logic pipeHit;
    logic exhaustNow;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q         <= IDLE;
            target_q        <= '0;
            overflow_seen_q <= 1'b0;
            v1_q            <= 1'b0;
            nonce1_q        <= '0;
            lt_hi_q         <= 1'b0;
            eq_hi_q         <= 1'b0;
            digest_lo_q     <= '0;
            v2_q            <= 1'b0;
            nonce2_q        <= '0;
            hit_q           <= 1'b0;
            win_nonce_q     <= '0;
            count_q         <= '0;
        end else begin
            state_q         <= state_d;
            target_q        <= target_d;
            overflow_seen_q <= overflow_seen_d;
            v1_q            <= v1_d;
            nonce1_q        <= nonce1_d;
            lt_hi_q         <= lt_hi_d;
            eq_hi_q         <= eq_hi_d;
            digest_lo_q     <= digest_lo_d;
            v2_q            <= v2_d;
            nonce2_q        <= nonce2_d;
            hit_q           <= hit_d;
            win_nonce_q     <= win_nonce_d;
            count_q         <= count_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        target_d        = target_q;
        overflow_seen_d = overflow_seen_q;
        win_nonce_d     = win_nonce_q;
        count_d         = count_q;

        acceptStart = (state_q == IDLE) && start && !abort;
        inSearch    = (state_q == SEARCH) && !abort;

        // Valids only advance while searching, so leaving SEARCH flushes the pipe.
        v1_d        = inSearch && hash_valid;
        nonce1_d    = hash_nonce;
        lt_hi_d     = hash_digest[HASH_W-1:HALF] < target_q[HASH_W-1:HALF];
        eq_hi_d     = hash_digest[HASH_W-1:HALF] == target_q[HASH_W-1:HALF];
        digest_lo_d = hash_digest[HALF-1:0];

        v2_d     = inSearch && v1_q;
        nonce2_d = nonce1_q;
        hit_d    = lt_hi_q || (eq_hi_q && (digest_lo_q < target_q[HALF-1:0]));

        pipeHit    = v2_q && hit_q;
        exhaustNow = overflow_seen_q && hash_idle && !hash_valid && !v1_q && !pipeHit;

        if (inSearch && gen_overflow) begin
            overflow_seen_d = 1'b1;
        end
        if (inSearch && v2_q && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (acceptStart) begin
                    state_d         = CLEAR;
                    target_d        = target;
                    overflow_seen_d = 1'b0;
                    win_nonce_d     = '0;
                    count_d         = '0;
                end
            end
            CLEAR: begin
                state_d = abort ? IDLE : SEARCH;
            end
            SEARCH: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (pipeHit) begin
                    state_d     = FOUND;
                    win_nonce_d = nonce2_q;
                end else if (exhaustNow) begin
                    state_d = EXHAUSTED;
                end
            end
            FOUND, EXHAUSTED: begin
                if (abort || result_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign gen_reset     = (state_q == CLEAR);
    assign gen_enable    = (state_q == SEARCH);
    assign found         = (state_q == FOUND);
    assign exhausted     = (state_q == EXHAUSTED);
    assign win_nonce     = win_nonce_q;
    assign checked_count = count_q;

endmodule
